// File: rtl/l2_meta_pkg.sv
// Shared types and helpers for the L2 metadata array.
package l2_meta_pkg;

    // The flush engine is either idle (normal ports live) or walking the sets.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // One-bit masked merge: take the new bit where the mask is set, otherwise
    // keep the stored bit. Applied bit by bit so it is independent of WIDTH,
    // and shared by the write path and the read forwarding path so both
    // always agree on the post-write value.
    function automatic logic mask_merge(
        input logic old_bit,
        input logic new_bit,
        input logic mask_bit
    );
        return mask_bit ? new_bit : old_bit;
    endfunction

endpackage

// File: rtl/l2_flush_seq.sv
// Flush sequencer: walks every set index once, one per cycle, and reports
// busy for exactly 2**S_INDEX cycles. Requests are ignored while walking.
module l2_flush_seq
    import l2_meta_pkg::*;
#(
    parameter int S_INDEX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic               busy,
    output logic               flush_we,
    output logic [S_INDEX-1:0] flush_idx
);

    localparam logic [S_INDEX-1:0] LAST_IDX = {S_INDEX{1'b1}};

    flush_state_t       state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;

    // Next state: start on a request from IDLE, stop after clearing the last set.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + S_INDEX'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any flush in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == FLUSH);
    assign flush_we  = (state_q == FLUSH);
    assign flush_idx = cnt_q;

endmodule

// File: rtl/l2_meta_array.sv
// L2 metadata array: one masked write port, NUM_RPORTS registered read ports
// with write-to-read forwarding, a per-set valid bitmap, a probe port and a
// set-per-cycle flush engine sharing the single write port.
module l2_meta_array
    import l2_meta_pkg::*;
#(
    parameter int S_INDEX    = 4,
    parameter int WIDTH      = 24,
    parameter int NUM_RPORTS = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_RPORTS-1:0]               read,
    input  logic [NUM_RPORTS-1:0][S_INDEX-1:0]  rindex,
    output logic [NUM_RPORTS-1:0][WIDTH-1:0]    dataout,
    output logic [NUM_RPORTS-1:0]               vout,
    output logic [NUM_RPORTS-1:0][WIDTH-1:0]    dataout_imm,
    input  logic                                load,
    input  logic [S_INDEX-1:0]                  windex,
    input  logic [WIDTH-1:0]                    wmask,
    input  logic [WIDTH-1:0]                    datain,
    input  logic                                flush,
    output logic                                busy,
    input  logic [S_INDEX-1:0]                  pindex,
    output logic [WIDTH-1:0]                    pout,
    output logic                                pvalid
);

    localparam int NUM_SETS = 2 ** S_INDEX;

    // Storage
    logic [WIDTH-1:0]    data_q [NUM_SETS];
    logic [WIDTH-1:0]    data_d [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q, valid_d;

    // Read port registers
    logic [NUM_RPORTS-1:0][WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_RPORTS-1:0]            rd_valid_q, rd_valid_d;

    // Flush engine interface
    logic               flush_we;
    logic [S_INDEX-1:0] flush_idx;

    // Write path: a user write only happens while the flush engine is idle.
    logic             wr_en;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;

    assign wr_en  = load & ~busy;
    assign wr_old = data_q[windex];

    l2_flush_seq #(
        .S_INDEX (S_INDEX)
    ) u_flush (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .busy      (busy),
        .flush_we  (flush_we),
        .flush_idx (flush_idx)
    );

    // Post-write value of the addressed set, merged bit by bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
        assign wr_merged[gi] = mask_merge(wr_old[gi], datain[gi], wmask[gi]);
    end

    // Per-set next value: flush clear wins, then user write, else hold.
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
        logic set_wr;
        logic set_fl;
        assign set_wr      = wr_en && (windex == S_INDEX'(gi));
        assign set_fl      = flush_we && (flush_idx == S_INDEX'(gi));
        assign data_d[gi]  = set_fl ? '0 : (set_wr ? wr_merged : data_q[gi]);
        assign valid_d[gi] = set_fl ? 1'b0 : (set_wr ? 1'b1 : valid_q[gi]);
    end

    // Storage registers; reset defines every set so nothing reads back as X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SETS; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
        end
    end

    // Per-port read: hold when idle or flushing, forward the merged write on a
    // same-index collision, otherwise capture the stored set.
    for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
        logic rd_en;
        logic fwd;
        assign rd_en = read[gi] && !busy;
        assign fwd   = wr_en && (rindex[gi] == windex);

        assign rd_data_d[gi]  = !rd_en ? rd_data_q[gi]
                              : (fwd ? wr_merged : data_q[rindex[gi]]);
        assign rd_valid_d[gi] = !rd_en ? rd_valid_q[gi]
                              : (fwd ? 1'b1 : valid_q[rindex[gi]]);

        assign dataout_imm[gi] = data_q[rindex[gi]];
    end

    // Read data/valid output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign dataout = rd_data_q;
    assign vout    = rd_valid_q;
    assign pout    = data_q[pindex];
    assign pvalid  = valid_q[pindex];

endmodule

// File: tb/tb_l2_meta_array.sv
// Directed self-checking bench for l2_meta_array (default parameters).
module tb_l2_meta_array;

    localparam int S_INDEX    = 4;
    localparam int WIDTH      = 24;
    localparam int NUM_RPORTS = 2;
    localparam int NUM_SETS   = 16;

    logic                               clk = 1'b0;
    logic                               rst;
    logic [NUM_RPORTS-1:0]              read;
    logic [NUM_RPORTS-1:0][S_INDEX-1:0] rindex;
    logic [NUM_RPORTS-1:0][WIDTH-1:0]   dataout;
    logic [NUM_RPORTS-1:0]              vout;
    logic [NUM_RPORTS-1:0][WIDTH-1:0]   dataout_imm;
    logic                               load;
    logic [S_INDEX-1:0]                 windex;
    logic [WIDTH-1:0]                   wmask;
    logic [WIDTH-1:0]                   datain;
    logic                               flush;
    logic                               busy;
    logic [S_INDEX-1:0]                 pindex;
    logic [WIDTH-1:0]                   pout;
    logic                               pvalid;

    int checks   = 0;
    int failures = 0;
    int busy_cycles;

    l2_meta_array #(
        .S_INDEX    (S_INDEX),
        .WIDTH      (WIDTH),
        .NUM_RPORTS (NUM_RPORTS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read        (read),
        .rindex      (rindex),
        .dataout     (dataout),
        .vout        (vout),
        .dataout_imm (dataout_imm),
        .load        (load),
        .windex      (windex),
        .wmask       (wmask),
        .datain      (datain),
        .flush       (flush),
        .busy        (busy),
        .pindex      (pindex),
        .pout        (pout),
        .pvalid      (pvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [S_INDEX-1:0] idx, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] m);
        load = 1'b1; windex = idx; datain = d; wmask = m;
        tick();
        load = 1'b0;
    endtask

    task automatic probe(input logic [S_INDEX-1:0] idx);
        pindex = idx;
        #1;
    endtask

    initial begin
        rst = 1'b1; read = '0; rindex = '0; load = 1'b0; windex = '0;
        wmask = '0; datain = '0; flush = 1'b0; pindex = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dataout0", 32'(dataout[0]), 32'd0);
        check("reset_vout", 32'(vout), 32'd0);
        for (int i = 0; i < NUM_SETS; i++) begin
            probe(S_INDEX'(i));
            check($sformatf("reset_pout[%0d]", i), 32'(pout), 32'd0);
            check($sformatf("reset_pvalid[%0d]", i), 32'(pvalid), 32'd0);
        end

        // Read port 0 at index 3 after reset
        read = 2'b01; rindex[0] = 4'd3;
        tick();
        read = '0;
        check("rd3_dataout0", 32'(dataout[0]), 32'd0);
        check("rd3_vout0", 32'(vout[0]), 32'd0);

        // Masked write to index 5
        wr(4'd5, 24'hFFFFFF, 24'hFFFFFF);
        wr(4'd5, 24'h000000, 24'h0000FF);
        read = 2'b01; rindex[0] = 4'd5;
        tick();
        read = '0;
        check("mask_dataout0", 32'(dataout[0]), 32'hFFFF00);
        check("mask_vout0", 32'(vout[0]), 32'd1);
        probe(4'd5);
        check("mask_pout5", 32'(pout), 32'hFFFF00);

        // Zero mask still sets the valid bit
        wr(4'd10, 24'hFFFFFF, 24'h000000);
        probe(4'd10);
        check("zmask_pvalid10", 32'(pvalid), 32'd1);
        check("zmask_pout10", 32'(pout), 32'd0);

        // Forwarding on port 1
        wr(4'd7, 24'h123456, 24'hFFFFFF);
        load = 1'b1; windex = 4'd7; datain = 24'hABCDEF; wmask = 24'hFF0000;
        read = 2'b10; rindex[1] = 4'd7;
        #1;
        check("fwd_imm1_prewrite", 32'(dataout_imm[1]), 32'h123456);
        tick();
        load = 1'b0; read = '0;
        check("fwd_dataout1", 32'(dataout[1]), 32'hAB3456);
        check("fwd_vout1", 32'(vout[1]), 32'd1);
        probe(4'd7);
        check("fwd_pout7", 32'(pout), 32'hAB3456);

        // Dual read, then per-port hold
        wr(4'd2, 24'h000222, 24'hFFFFFF);
        wr(4'd9, 24'h000999, 24'hFFFFFF);
        read = 2'b11; rindex[0] = 4'd2; rindex[1] = 4'd2;
        tick();
        check("dual_dataout0", 32'(dataout[0]), 32'h000222);
        check("dual_dataout1", 32'(dataout[1]), 32'h000222);
        check("dual_vout", 32'(vout), 32'h3);
        read = 2'b10; rindex[0] = 4'd9; rindex[1] = 4'd9;
        tick();
        check("p1_idx9_dataout1", 32'(dataout[1]), 32'h000999);
        check("p0_hold_dataout0", 32'(dataout[0]), 32'h000222);
        read = 2'b01;
        tick();
        read = '0;
        check("p0_idx9_dataout0", 32'(dataout[0]), 32'h000999);

        // Fill all sets, capture two values on the read ports
        for (int i = 0; i < NUM_SETS; i++) begin
            wr(S_INDEX'(i), 24'h100000 | 24'(i), 24'hFFFFFF);
        end
        read = 2'b11; rindex[0] = 4'd4; rindex[1] = 4'd11;
        tick();
        read = '0;
        check("pre_flush_dataout0", 32'(dataout[0]), 32'h100004);
        check("pre_flush_dataout1", 32'(dataout[1]), 32'h10000B);

        // Flush pulse; a load in the same cycle is still performed
        flush = 1'b1; load = 1'b1; windex = 4'd15; datain = 24'hABCDEF; wmask = 24'hFFFFFF;
        tick();
        flush = 1'b0; load = 1'b0;
        probe(4'd15);
        check("flush_req_load_pout15", 32'(pout), 32'hABCDEF);
        busy_cycles = 0;
        for (int n = 0; n < 40 && busy; n++) begin
            busy_cycles++;
            if (busy_cycles == 8) begin
                // Ignored during flush: no write, no read capture, no restart.
                load = 1'b1; windex = 4'd0; datain = 24'hFFFFFF; wmask = 24'hFFFFFF;
                read = 2'b11; rindex[0] = 4'd15; rindex[1] = 4'd15;
                flush = 1'b1;
            end else begin
                load = 1'b0; read = '0; flush = 1'b0;
            end
            tick();
            if (busy_cycles == 8) begin
                check("flush_hold_dataout0", 32'(dataout[0]), 32'h100004);
            end
        end
        load = 1'b0; read = '0; flush = 1'b0;
        check("flush_busy_cycles", 32'(busy_cycles), 32'd16);
        check("flush_busy_low", 32'(busy), 32'd0);
        check("flush_dataout0", 32'(dataout[0]), 32'h100004);
        check("flush_dataout1", 32'(dataout[1]), 32'h10000B);
        check("flush_vout", 32'(vout), 32'h3);
        for (int i = 0; i < NUM_SETS; i++) begin
            probe(S_INDEX'(i));
            check($sformatf("flush_pout[%0d]", i), 32'(pout), 32'd0);
            check($sformatf("flush_pvalid[%0d]", i), 32'(pvalid), 32'd0);
        end

        // Reset in the middle of a flush
        wr(4'd12, 24'h00ABCD, 24'hFFFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("mid_busy_start", 32'(busy), 32'd1);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dataout0", 32'(dataout[0]), 32'd0);
        check("mid_rst_vout", 32'(vout), 32'd0);
        wr(4'd12, 24'h00ABCD, 24'hFFFFFF);
        probe(4'd12);
        check("mid_wr_idle_pvalid12", 32'(pvalid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 40 && busy; n++) begin
            busy_cycles++;
            tick();
        end
        check("reflush_busy_cycles", 32'(busy_cycles), 32'd16);
        probe(4'd12);
        check("reflush_pvalid12", 32'(pvalid), 32'd0);
        check("reflush_pout12", 32'(pout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_meta_array.md
Name: l2_meta_array

Overview:
- Parametrised register array for L2 tag, valid, dirty and LRU metadata.
- Successor to the single-port L2 array: adds NUM_RPORTS independent registered read ports, bit-masked writes with merged write-to-read forwarding, and a per-set valid bitmap.
- Adds a multi-cycle flush engine that clears one set per cycle through the single write port, so the storage can map to a 1W RAM.
- Sits beside the L2 controller, which pulses flush on invalidate-all and stalls on busy.

Parameters:
- S_INDEX, 4, index width; NUM_SETS = 2**S_INDEX.
- WIDTH, 24, data bits per set.
- NUM_RPORTS, 2, number of registered read ports (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- read  in  NUM_RPORTS  per-port read enable.
- rindex  in  NUM_RPORTS x S_INDEX  per-port read index.
- dataout  out  NUM_RPORTS x WIDTH  registered read data.
- vout  out  NUM_RPORTS  registered valid bit of the set read.
- dataout_imm  out  NUM_RPORTS x WIDTH  combinational data[rindex[p]].
- load  in  1  write enable.
- windex  in  S_INDEX  write index.
- wmask  in  WIDTH  per-bit write mask; 1 = bit is written.
- datain  in  WIDTH  write data.
- flush  in  1  one-cycle flush request.
- busy  out  1  high while the flush engine runs.
- pindex  in  S_INDEX  probe index.
- pout  out  WIDTH  combinational data[pindex].
- pvalid  out  1  combinational valid[pindex].

Behaviour:
- Reset (rst=1 at a clock edge): all data sets = 0, all valid bits = 0, dataout = 0, vout = 0, busy = 0, FSM = IDLE, flush counter = 0. Reset overrides everything, including a flush in progress.
- Write, IDLE only: on a load edge, data[windex] <= (datain & wmask) | (data[windex] & ~wmask) and valid[windex] <= 1. wmask = 0 still sets the valid bit.
- Read port p, IDLE only, latency 1: on a read[p] edge, dataout[p]/vout[p] <= data[rindex[p]]/valid[rindex[p]].
- Forwarding: if load is high and rindex[p] == windex in the same cycle, the read returns the merged post-write value and vout = 1.
- Multiple ports may read the same index in the same cycle; all get identical results.
- read[p] = 0: dataout[p] and vout[p] hold their previous values.
- dataout_imm, pout and pvalid are combinational on current storage. They show the pre-write value in a write cycle and remain live during flush.
- FSM states: IDLE and FLUSH.
  - IDLE -> FLUSH when flush = 1. Counter <= 0 and busy rises on that same edge.
  - A load in the flush-request cycle is still performed.
  - In FLUSH, each edge writes data[cnt] = 0 and valid[cnt] = 0, then cnt increments.
  - FLUSH -> IDLE on the edge that clears set NUM_SETS-1. busy falls on that edge.
  - busy is high for exactly NUM_SETS cycles.
- During FLUSH: load, read and flush inputs are ignored (no write, outputs hold, no restart). The caller must hold the request until busy is low.
- Counter width is S_INDEX; termination is at all-ones, with no wrap into a second pass.
- Widths: all index compares are exactly S_INDEX bits; no X-propagation from unwritten sets, since reset defines everything.

Decomposition:
- Package l2_meta_pkg holds:
  - typedef enum logic {IDLE, FLUSH} flush_state_t;
  - function mask_merge(old, new, mask), used by both the write path and forwarding.
- Optional sub-module l2_flush_seq (FSM, counter, busy), parameterised by S_INDEX. Port logic stays in the top module.

Test Plan:
- Reset then probe all sets: every pout = 0, pvalid = 0, busy = 0. Read port 0 at index 3: dataout = 0, vout = 0 next cycle.
- Masked write: load idx 5 with datain=0xFFFFFF, wmask=0xFFFFFF, then datain=0x000000, wmask=0x0000FF. Next read of idx 5 returns 0xFFFF00 with vout = 1.
- Forwarding: idx 7 holds 0x123456. Same cycle: load idx 7 with datain=0xABCDEF, wmask=0xFF0000, plus read port 1 idx 7 -> dataout[1] = 0xAB3456 next cycle, while dataout_imm[1] = 0x123456 during the write cycle.
- Dual read: port 0 reads idx 2 and port 1 reads idx 2, then idx 9, in consecutive cycles. Each port returns the correct data; a port with read = 0 holds its value.
- Flush: fill all 16 sets, pulse flush. busy is high for exactly 16 cycles. A load to idx 0 at cycle 8 has no effect. After busy falls, all pvalid = 0 and pout = 0, and dataout is unchanged during flush.
- Reset mid-flush: assert rst at flush cycle 5. Next cycle busy = 0 and the FSM is IDLE. A new flush pulse then completes in exactly 16 cycles.
